// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/compare, iterative MULU/DIVU.
// Define ALU_MC_DIV_EN to build the restoring divider; otherwise op 8 is illegal.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  // state  | meaning
  // IDLE   | no result held, ready for an operation
  // BUSY   | MULU/DIVU iterating, one bit per cycle
  // DONE   | result registers hold an unconsumed result
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NOR  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_MULU = 4'd7;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd8;
`endif

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] work_b;
  logic             accept;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_ovf;
  logic             sc_err;
  logic             sc_long;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign sum      = a + b;
  assign diff     = a - b;

  always_comb begin
    sc_res  = '0;
    sc_hi   = '0;
    sc_ovf  = 1'b0;
    sc_err  = 1'b0;
    sc_long = 1'b0;
    case (op)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_NOR:  sc_res = ~(a | b);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MULU: sc_long = 1'b1;
`ifdef ALU_MC_DIV_EN
      OP_DIVU: begin
        if (b == '0) begin
          sc_res = '1;
          sc_hi  = a;
          sc_err = 1'b1;
        end else begin
          sc_long = 1'b1;
        end
      end
`endif
      default: sc_err = 1'b1;
    endcase
  end

  // Shift-add: conditionally add multiplicand to the high half, then shift the pair right.
  assign mul_sum = {1'b0, work_hi} + ({1'b0, work_b} & {(WIDTH+1){work_lo[0]}});

`ifdef ALU_MC_DIV_EN
  logic           is_div;
  logic [WIDTH:0] trial;

  // Restoring step: work_hi is the partial remainder, work_lo shifts dividend out / quotient in.
  assign trial = {work_hi, work_lo[WIDTH-1]} - {1'b0, work_b};

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        step_hi = trial[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {work_hi[WIDTH-2:0], work_lo[WIDTH-1]};
        step_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div <= 1'b0;
    end else if (accept) begin
      is_div <= (op == OP_DIVU);
    end
  end
`else
  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      work_b    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_BUSY: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          if (cnt == '0) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= step_lo;
            result_hi <= step_hi;
            zero      <= (step_lo == '0);
            ovf       <= 1'b0;
            err       <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (accept) begin
            if (sc_long) begin
              state     <= S_BUSY;
              cnt       <= CW'(WIDTH - 1);
              work_hi   <= '0;
              work_lo   <= a;
              work_b    <= b;
              out_valid <= 1'b0;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= sc_res;
              result_hi <= sc_hi;
              zero      <= (sc_res == '0);
              ovf       <= sc_ovf;
              err       <= sc_err;
            end
          end else if ((state == S_DONE) && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
